prim_clock_switch_ctrl: RTL and testbench

Parametrised controller that sequences a glitch-free switch between `NumClk` clock sources. It generalises the two-input select to N channels and adds a break-before-make handshake, a programmable dead gap, a timeout and error reporting. It lives in the control clock domain and drives the per-channel clock-gate enables. It consumes per-channel gate status that has already been synchronised into `clk_i`.

---
 rtl/prim_clock_switch_pkg.sv | 21 ++
 rtl/prim_clock_switch_timer.sv | 38 +++
 rtl/prim_clock_switch_ctrl.sv | 147 ++++++++++++++
 tb/tb_prim_clock_switch_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_clock_switch_pkg.sv
// Shared types and helpers for the N-way glitch-free clock switch controller.
package prim_clock_switch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BREAK = 3'd1,
        ST_GAP   = 3'd2,
        ST_MAKE  = 3'd3,
        ST_DONE  = 3'd4
    } clk_sw_state_e;

    // One-hot decode of sel, masked to num_clk channels (num_clk <= 32).
    function automatic logic [31:0] onehot(input logic [31:0] sel, input int unsigned num_clk);
        logic [31:0] mask;
        logic [31:0] oh;
        mask = (num_clk >= 32) ? '1 : ((32'd1 << num_clk) - 32'd1);
        oh   = 32'd1 << sel;
        return oh & mask;
    endfunction

endpackage

// File: rtl/prim_clock_switch_timer.sv
// Saturating cycle counter shared by the gap wait and the status-edge timeouts.
module prim_clock_switch_timer #(
    parameter int unsigned MaxCount = 64,
    parameter int unsigned CntW     = $clog2(MaxCount + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            en_i,
    output logic [CntW-1:0] cnt_o,
    output logic            expired_o
);

    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxCount);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign expired_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/prim_clock_switch_ctrl.sv
// Break-before-make sequencer for N clock gates with dead gap, timeouts and error pulse.
module prim_clock_switch_ctrl
    import prim_clock_switch_pkg::*;
#(
    parameter int unsigned NumClk        = 4,
    parameter int unsigned SelW          = $clog2(NumClk),
    parameter int unsigned DefaultSel    = 0,
    parameter int unsigned GapCycles     = 2,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [SelW-1:0]   sel_i,
    output logic              ready_o,
    output logic [NumClk-1:0] en_o,
    input  logic [NumClk-1:0] status_i,
    output logic [SelW-1:0]   cur_sel_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned       CntW    = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0]   GapThr  = CntW'(GapCycles - 1);
    localparam logic [NumClk-1:0] DefEn   = {{(NumClk-1){1'b0}}, 1'b1} << DefaultSel;
    localparam logic [SelW-1:0]   DefSel  = SelW'(DefaultSel);
    localparam logic [SelW:0]     NumClkW = (SelW+1)'(NumClk);

    clk_sw_state_e     state_q, state_d;
    logic [NumClk-1:0] en_q, en_d;
    logic [SelW-1:0]   cur_sel_q, cur_sel_d;
    logic [SelW-1:0]   tgt_q, tgt_d;
    logic              err_lat_q, err_lat_d;
    logic              ready_q, busy_q, done_q, err_q;
    logic              timer_clr, timer_en, timer_expired;
    logic [CntW-1:0]   timer_cnt;

    prim_clock_switch_timer #(
        .MaxCount (TimeoutCycles),
        .CntW     (CntW)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .cnt_o     (timer_cnt),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        cur_sel_d = cur_sel_q;
        tgt_d     = tgt_q;
        err_lat_d = err_lat_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_i && ready_q) begin
                    tgt_d     = sel_i;
                    err_lat_d = 1'b0;
                    if ({1'b0, sel_i} >= NumClkW) begin
                        err_lat_d = 1'b1;
                        state_d   = ST_DONE;
                    end else if (sel_i == cur_sel_q) begin
                        state_d = ST_DONE;
                    end else begin
                        en_d      = '0;
                        timer_clr = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                timer_en = 1'b1;
                // A status drop wins over a timeout landing in the same cycle.
                if (!status_i[cur_sel_q]) begin
                    timer_clr = 1'b1;
                    state_d   = ST_GAP;
                end else if (timer_expired) begin
                    en_d      = NumClk'(onehot(32'(cur_sel_q), NumClk));
                    err_lat_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_GAP: begin
                timer_en = 1'b1;
                if (timer_cnt == GapThr) begin
                    en_d      = NumClk'(onehot(32'(tgt_q), NumClk));
                    cur_sel_d = tgt_q;
                    timer_clr = 1'b1;
                    state_d   = ST_MAKE;
                end
            end
            ST_MAKE: begin
                timer_en = 1'b1;
                if (status_i[tgt_q]) begin
                    state_d = ST_DONE;
                end else if (timer_expired) begin
                    err_lat_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags are registered off the next state so every output is a flop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            en_q      <= DefEn;
            cur_sel_q <= DefSel;
            tgt_q     <= DefSel;
            err_lat_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            cur_sel_q <= cur_sel_d;
            tgt_q     <= tgt_d;
            err_lat_q <= err_lat_d;
            ready_q   <= (state_d == ST_IDLE);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
            err_q     <= (state_d == ST_DONE) && err_lat_d;
        end
    end

    assign ready_o   = ready_q;
    assign en_o      = en_q;
    assign cur_sel_o = cur_sel_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_prim_clock_switch_ctrl.sv
// Scenario bench for the clock switch controller: scoreboard of expected completions plus inline checks.
module tb_prim_clock_switch_ctrl;

    localparam int NCLK = 4;
    localparam int SW   = 2;

    typedef struct {
        int             cyc;
        logic           err;
        logic [NCLK-1:0] en;
        logic [SW-1:0]  cur;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic            rst_n;
    logic            req;
    logic [SW-1:0]   sel;
    logic            ready, busy, done, err;
    logic [NCLK-1:0] en, status, hold_mask, block_mask;
    logic [SW-1:0]   cur;

    assign status = (en | hold_mask) & ~block_mask;

    prim_clock_switch_ctrl #(
        .NumClk        (4),
        .DefaultSel    (2),
        .GapCycles     (2),
        .TimeoutCycles (8)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .sel_i     (sel),
        .ready_o   (ready),
        .en_o      (en),
        .status_i  (status),
        .cur_sel_o (cur),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err)
    );

    logic       req5;
    logic [2:0] sel5, cur5;
    logic [4:0] en5;
    logic       ready5, busy5, done5, err5;

    prim_clock_switch_ctrl #(
        .NumClk        (5),
        .DefaultSel    (0),
        .GapCycles     (2),
        .TimeoutCycles (8)
    ) dut5 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req5),
        .sel_i     (sel5),
        .ready_o   (ready5),
        .en_o      (en5),
        .status_i  (en5),
        .cur_sel_o (cur5),
        .busy_o    (busy5),
        .done_o    (done5),
        .err_o     (err5)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    // Completion monitor: every done_o pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL done_unexpected cyc=%0d got en=%b cur=%0d err=%b required no done", cyc, en, cur, err);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (cyc !== mon_e.cyc || err !== mon_e.err || en !== mon_e.en || cur !== mon_e.cur) begin
                        n_err++;
                        $display("FAIL done_txn got cyc=%0d err=%b en=%b cur=%0d required cyc=%0d err=%b en=%b cur=%0d",
                                 cyc, err, en, cur, mon_e.cyc, mon_e.err, mon_e.en, mon_e.cur);
                    end else begin
                        $display("txn done cyc=%0d err=%b en=%b cur=%0d", cyc, err, en, cur);
                    end
                end
            end
            if (err && !done) begin
                n_vec++;
                n_err++;
                $display("FAIL err_without_done cyc=%0d got err=1 required err=0", cyc);
            end
        end
    end

    // Caller is positioned at a negedge; req is sampled at the following edge.
    task automatic drive_req(input logic [SW-1:0] s, input bit expect_done, input int lat,
                             input logic e_err, input logic [NCLK-1:0] e_en, input logic [SW-1:0] e_cur,
                             output int t);
        exp_t e;
        req = 1'b1;
        sel = s;
        t   = cyc;
        if (expect_done) begin
            e.cyc = t + lat;
            e.err = e_err;
            e.en  = e_en;
            e.cur = e_cur;
            sb_q.push_back(e);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL done_timeout got pending=%0d required pending=0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (en !== 4'b0100) begin n_err++; $display("FAIL reset_en got %b required 0100", en); end
        n_vec++; if (cur !== 2'd2) begin n_err++; $display("FAIL reset_cur got %0d required 2", cur); end
        n_vec++; if (ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL reset_ready_busy got %b%b required 10", ready, busy); end
        n_vec++; if (done !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL reset_done_err got %b%b required 00", done, err); end
        n_vec++; if (en5 !== 5'b00001 || cur5 !== 3'd0) begin n_err++; $display("FAIL reset_dut5 got en=%b cur=%0d required 00001/0", en5, cur5); end
        $display("txn reset en=%b cur=%0d", en, cur);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_switch();
        int t;
        drive_req(2'd0, 1'b1, 5, 1'b0, 4'b0001, 2'd0, t);
        n_vec++; if (ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL switch_busy got ready=%b busy=%b required 0/1", ready, busy); end
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            n_vec++;
            if (k < 4 && en !== 4'b0000) begin
                n_err++; $display("FAIL switch_gap_en T+%0d got %b required 0000", k, en);
            end else if (k == 4 && (en !== 4'b0001 || cur !== 2'd0)) begin
                n_err++; $display("FAIL switch_make_en T+4 got en=%b cur=%0d required 0001/0", en, cur);
            end
        end
        wait_done();
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL switch_ready_after got %b required 1", ready); end
    endtask

    task automatic test_same();
        int t;
        drive_req(2'd0, 1'b1, 1, 1'b0, 4'b0001, 2'd0, t);
        wait_done();
    endtask

    task automatic test_invalid();
        req5 = 1'b1;
        sel5 = 3'd5;
        @(negedge clk);
        req5 = 1'b0;
        n_vec++;
        if (done5 !== 1'b1 || err5 !== 1'b1 || en5 !== 5'b00001 || cur5 !== 3'd0 || ready5 !== 1'b0) begin
            n_err++;
            $display("FAIL invalid_sel got done=%b err=%b en=%b cur=%0d ready=%b required 1/1/00001/0/0", done5, err5, en5, cur5, ready5);
        end else begin
            $display("txn invalid sel=5 done err en=%b", en5);
        end
        @(negedge clk);
        n_vec++;
        if (done5 !== 1'b0 || err5 !== 1'b0 || ready5 !== 1'b1 || busy5 !== 1'b0) begin
            n_err++;
            $display("FAIL invalid_after got done=%b err=%b ready=%b busy=%b required 0/0/1/0", done5, err5, ready5, busy5);
        end
    endtask

    task automatic test_break_timeout();
        int t;
        hold_mask = 4'b0001;
        drive_req(2'd3, 1'b1, 10, 1'b1, 4'b0001, 2'd0, t);
        repeat (8) @(negedge clk);
        n_vec++; if (en !== 4'b0000) begin n_err++; $display("FAIL break_hold_en T+9 got %b required 0000", en); end
        wait_done();
        hold_mask = 4'b0000;
    endtask

    task automatic test_make_timeout();
        int t;
        block_mask = 4'b0100;
        drive_req(2'd2, 1'b1, 13, 1'b1, 4'b0100, 2'd2, t);
        wait_done();
        block_mask = 4'b0000;
        n_vec++; if (en !== 4'b0100 || cur !== 2'd2) begin n_err++; $display("FAIL make_timeout_keep got en=%b cur=%0d required 0100/2", en, cur); end
    endtask

    task automatic test_req_ignored();
        int t;
        drive_req(2'd1, 1'b1, 5, 1'b0, 4'b0010, 2'd1, t);
        req = 1'b1;
        sel = 2'd3;
        repeat (2) @(negedge clk);
        req = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        n_vec++; if (cur !== 2'd1 || en !== 4'b0010) begin n_err++; $display("FAIL ignored_req got en=%b cur=%0d required 0010/1", en, cur); end
    endtask

    task automatic test_back_to_back();
        int  t;
        bool_loop: begin end
        drive_req(2'd0, 1'b1, 5, 1'b0, 4'b0001, 2'd0, t);
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            @(negedge clk);
        end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got %b required 1", done); end
        @(negedge clk);
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b required 1", ready); end
        drive_req(2'd3, 1'b1, 5, 1'b0, 4'b1000, 2'd3, t);
        wait_done();
    endtask

    task automatic test_reset_mid();
        int t;
        drive_req(2'd1, 1'b0, 0, 1'b0, 4'b0000, 2'd0, t);
        @(negedge clk);
        n_vec++; if (en !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL rstmid_gap got en=%b busy=%b required 0000/1", en, busy); end
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if (en !== 4'b0100 || cur !== 2'd2 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_values got en=%b cur=%0d ready=%b busy=%b done=%b required 0100/2/1/0/0", en, cur, ready, busy, done);
        end else begin
            $display("txn reset_mid en=%b cur=%0d", en, cur);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++; if (en !== 4'b0100 || ready !== 1'b1) begin n_err++; $display("FAIL rstmid_after got en=%b ready=%b required 0100/1", en, ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req        = 1'b0;
        sel        = '0;
        req5       = 1'b0;
        sel5       = '0;
        hold_mask  = '0;
        block_mask = '0;
        @(negedge clk);
        test_reset();
        test_switch();
        test_same();
        test_invalid();
        test_break_timeout();
        test_make_timeout();
        test_req_ignored();
        test_back_to_back();
        test_reset_mid();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got pending=%0d required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
